mbist_sequencer: RTL

Host-side sequencer for the memory BIST controller. It drives the BIST 11-bit configuration word and monitors its status word, running an enabled subset of the four test patterns back to back: zero, ones, checkerboard, LFSR/MISR. Per-pattern pass/fail, timeout and abort status are collected into one result for the system register block.

---
 rtl/mbist_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mbist_sequencer.sv
// Host-side sequencer for the memory BIST controller: runs the enabled test patterns
// back to back and folds per-pattern pass/fail, timeout and abort into one result.
module mbist_sequencer #(
  parameter int ADDR_BITS = 5,
  parameter int TIMEOUT   = 2047
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [3:0]           pattern_mask,
  input  logic                 single_mode,
  input  logic [ADDR_BITS-1:0] target_addr,
  output logic [10:0]          bist_cfg,
  input  logic [10:0]          bist_status,
  output logic                 busy,
  output logic                 seq_done,
  output logic                 result_valid,
  output logic [3:0]           fail_vector,
  output logic                 timeout_flag,
  output logic                 aborted,
  output logic                 pass,
  output logic [1:0]           cur_pattern
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_CONFIG, S_ARM, S_WAIT, S_RELEASE, S_FINISH
  } state_t;

  state_t               state, state_n;
  logic [3:0]           mask_q;
  logic                 mode_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [2:0]           ptr, ptr_n, nxt;
  logic [15:0]          cnt, cnt_n;
  logic                 done, fail, tmo, latch, unused_status;
  logic [10:0]          cfg_n;
  logic [3:0]           fv_n;
  logic [1:0]           cur_n;
  logic                 busy_n, seq_done_n, rv_n, to_n, ab_n, pass_n;

  // Lowest enabled pattern index at or above 'from'; 4 means none left.
  function automatic logic [2:0] first_enabled(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] idx;
    idx = 3'd4;
    for (int i = 3; i >= 0; i--)
      if (mask[i] && (3'(i) >= from)) idx = 3'(i);
    return idx;
  endfunction

  function automatic logic [10:0] make_cfg(input logic [1:0] pat, input logic init);
    return {pat, 5'(addr_q), 2'b00, init, mode_q};
  endfunction

  assign done          = bist_status[2];
  assign fail          = bist_status[3];
  assign unused_status = ^{bist_status[10:4], bist_status[1:0]};
  assign tmo           = (cnt == 16'(TIMEOUT));
  assign nxt           = first_enabled(mask_q, ptr);
  assign latch         = (state == S_IDLE) && start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (start) state_n = S_SELECT;
      S_SELECT:  state_n = (abort || nxt[2]) ? S_FINISH : S_CONFIG;
      S_CONFIG:  state_n = abort ? S_RELEASE : S_ARM;
      S_ARM:     state_n = abort ? S_RELEASE : S_WAIT;
      S_WAIT:    if (done || tmo || abort) state_n = S_RELEASE;
      S_RELEASE: begin
        if (!done)    state_n = (aborted || abort) ? S_FINISH : S_SELECT;
        else if (tmo) state_n = S_FINISH;
      end
      S_FINISH:  state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // Next values of every registered output, derived from the current and next state.
  always_comb begin
    ptr_n = ptr;
    cur_n = cur_pattern;
    fv_n  = fail_vector;
    to_n  = timeout_flag;
    ab_n  = aborted;
    rv_n  = result_valid;
    cnt_n = cnt;
    if (latch) begin
      fv_n  = '0;
      to_n  = 1'b0;
      ab_n  = 1'b0;
      rv_n  = 1'b0;
      ptr_n = '0;
    end
    if (state == S_SELECT && !abort && !nxt[2]) cur_n = nxt[1:0];
    if (state == S_WAIT) begin
      if (done) fv_n[cur_pattern] = fail;
      else if (tmo) begin
        fv_n[cur_pattern] = 1'b1;
        to_n              = 1'b1;
      end
    end
    if (abort && state != S_IDLE && state != S_FINISH) ab_n = 1'b1;
    if (state == S_RELEASE) begin
      if (!done) ptr_n = {1'b0, cur_pattern} + 3'd1;
      else if (tmo) to_n = 1'b1;
    end
    if (state_n == S_FINISH) rv_n = 1'b1;

    if (state_n == S_ARM || (state_n == S_RELEASE && state != S_RELEASE)) cnt_n = '0;
    else if (state == S_ARM || state == S_WAIT || state == S_RELEASE)   cnt_n = cnt + 16'd1;

    case (state_n)
      S_SELECT:            cfg_n = bist_cfg & ~11'h002;
      S_CONFIG, S_RELEASE: cfg_n = make_cfg(cur_n, 1'b0);
      S_ARM, S_WAIT:       cfg_n = make_cfg(cur_n, 1'b1);
      default:             cfg_n = '0;
    endcase
    busy_n     = (state_n != S_IDLE) && (state_n != S_FINISH);
    seq_done_n = (state_n == S_FINISH);
    pass_n     = rv_n & ~|fv_n & ~to_n & ~ab_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bist_cfg     <= '0;
      busy         <= 1'b0;
      seq_done     <= 1'b0;
      result_valid <= 1'b0;
      fail_vector  <= '0;
      timeout_flag <= 1'b0;
      aborted      <= 1'b0;
      pass         <= 1'b0;
      cur_pattern  <= '0;
    end else begin
      bist_cfg     <= cfg_n;
      busy         <= busy_n;
      seq_done     <= seq_done_n;
      result_valid <= rv_n;
      fail_vector  <= fv_n;
      timeout_flag <= to_n;
      aborted      <= ab_n;
      pass         <= pass_n;
      cur_pattern  <= cur_n;
    end
  end

  always_ff @(posedge clk) begin
    if (latch) begin
      mask_q <= pattern_mask;
      mode_q <= single_mode;
      addr_q <= target_addr;
    end
    ptr <= ptr_n;
    cnt <= cnt_n;
  end

endmodule
